// File: rtl/sfp_prbs_checker_if.sv
// Receive-word stream and status bundle for the SFP0 PRBS-31 checker.
interface sfp_prbs_checker_if #(
    parameter int unsigned CNT_WIDTH = 32
);
    logic [31:0]          rx_data;
    logic                 rx_valid;
    logic                 clr;
    logic                 locked;
    logic                 err_sticky;
    logic [CNT_WIDTH-1:0] words_checked;
    logic [CNT_WIDTH-1:0] err_words;
    logic [CNT_WIDTH-1:0] bit_errs;
    logic [3:0]           status;

    modport master (
        output rx_data, rx_valid, clr,
        input  locked, err_sticky, words_checked, err_words, bit_errs, status
    );

    modport slave (
        input  rx_data, rx_valid, clr,
        output locked, err_sticky, words_checked, err_words, bit_errs, status
    );
endinterface

// File: rtl/sfp_prbs_checker.sv
// Self-synchronising PRBS-31 (x^31+x^28+1) receive checker with saturating
// word/bit error counters; bit 0 of each word is the earliest bit on the wire.
module sfp_prbs_checker #(
    parameter int unsigned LOCK_WORDS   = 16,
    parameter int unsigned UNLOCK_WORDS = 8,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input  logic              clk,
    input  logic              rst,
    sfp_prbs_checker_if.slave bus
);
    localparam int unsigned MATCH_W = $clog2(LOCK_WORDS + 1);
    localparam int unsigned BAD_W   = $clog2(UNLOCK_WORDS + 1);
    localparam int unsigned SUM_W   = ((CNT_WIDTH > 6) ? CNT_WIDTH : 6) + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [31:0]          expected_q, expected_d;
    logic [MATCH_W-1:0]   match_q, match_d;
    logic [BAD_W-1:0]     bad_q, bad_d;
    logic [CNT_WIDTH-1:0] wc_q, wc_d;
    logic [CNT_WIDTH-1:0] ew_q, ew_d;
    logic [CNT_WIDTH-1:0] be_q, be_d;
    logic                 sticky_q, sticky_d;
    logic                 locked_q;
    logic [3:0]           status_q;

    logic [31:0]          diff;
    logic [31:0]          rx_next;
    logic [31:0]          exp_next;
    logic [SUM_W-1:0]     be_sum;

    // Extend the 32-bit window by 32 more recurrence steps; the upper half is the next word.
    function automatic logic [31:0] prbs_next(input logic [31:0] w);
        logic [63:0] s;
        s = {32'h0, w};
        for (int k = 32; k < 64; k++) begin
            s[k] = s[k-31] ^ s[k-28];
        end
        return s[63:32];
    endfunction

    function automatic logic [5:0] popcount(input logic [31:0] d);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) begin
            c = c + 6'(d[i]);
        end
        return c;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_WIDTH'(1);
    endfunction

    assign diff     = bus.rx_data ^ expected_q;
    assign rx_next  = prbs_next(bus.rx_data);
    assign exp_next = prbs_next(expected_q);
    assign be_sum   = SUM_W'(be_q) + SUM_W'(popcount(diff));

    // Next-state and counter update
    always_comb begin
        state_d    = state_q;
        expected_d = expected_q;
        match_d    = match_q;
        bad_d      = bad_q;
        wc_d       = wc_q;
        ew_d       = ew_q;
        be_d       = be_q;
        sticky_d   = sticky_q;

        if (bus.rx_valid) begin
            case (state_q)
                HUNT: begin
                    if (bus.rx_data != 32'h0) begin
                        expected_d = rx_next;
                        match_d    = '0;
                        state_d    = SYNC;
                    end
                end
                SYNC: begin
                    if (diff == 32'h0) begin
                        match_d    = match_q + MATCH_W'(1);
                        expected_d = rx_next;
                        if (match_q + MATCH_W'(1) == MATCH_W'(LOCK_WORDS)) begin
                            state_d = LOCKED;
                            bad_d   = '0;
                        end
                    end else if (bus.rx_data != 32'h0) begin
                        expected_d = rx_next;
                        match_d    = '0;
                    end else begin
                        state_d = HUNT;
                    end
                end
                LOCKED: begin
                    // Free-running prediction so a bad word cannot corrupt the next expectation
                    expected_d = exp_next;
                    wc_d       = sat_inc(wc_q);
                    if (diff == 32'h0) begin
                        bad_d = '0;
                    end else begin
                        ew_d     = sat_inc(ew_q);
                        be_d     = (be_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : CNT_WIDTH'(be_sum);
                        sticky_d = 1'b1;
                        bad_d    = bad_q + BAD_W'(1);
                        if (bad_q + BAD_W'(1) == BAD_W'(UNLOCK_WORDS)) begin
                            state_d = HUNT;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        if (bus.clr) begin
            wc_d     = '0;
            ew_d     = '0;
            be_d     = '0;
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= HUNT;
            expected_q <= '0;
            match_q    <= '0;
            bad_q      <= '0;
            wc_q       <= '0;
            ew_q       <= '0;
            be_q       <= '0;
            sticky_q   <= 1'b0;
            locked_q   <= 1'b0;
            status_q   <= 4'b0001;
        end else begin
            state_q    <= state_d;
            expected_q <= expected_d;
            match_q    <= match_d;
            bad_q      <= bad_d;
            wc_q       <= wc_d;
            ew_q       <= ew_d;
            be_q       <= be_d;
            sticky_q   <= sticky_d;
            locked_q   <= (state_d == LOCKED);
            status_q   <= {sticky_d, state_d == LOCKED, state_d == SYNC, state_d == HUNT};
        end
    end

    assign bus.locked        = locked_q;
    assign bus.err_sticky    = sticky_q;
    assign bus.words_checked = wc_q;
    assign bus.err_words     = ew_q;
    assign bus.bit_errs      = be_q;
    assign bus.status        = status_q;
endmodule

// File: tb/tb_sfp_prbs_checker.sv
// Directed bench for sfp_prbs_checker: a 32-bit-counter and a 4-bit-counter
// instance share the stimulus and are checked each cycle against a word-level model.
module tb_sfp_prbs_checker;
    logic clk;
    logic rst;
    bit   started;
    int   n_checks;
    int   n_err;

    sfp_prbs_checker_if #(.CNT_WIDTH(32)) bus_a ();
    sfp_prbs_checker_if #(.CNT_WIDTH(4))  bus_b ();

    sfp_prbs_checker #(.LOCK_WORDS(16), .UNLOCK_WORDS(8), .CNT_WIDTH(32)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave)
    );
    sfp_prbs_checker #(.LOCK_WORDS(16), .UNLOCK_WORDS(8), .CNT_WIDTH(4)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: true (unbounded) counts; a saturating counter must read min(count, 2^W-1)
    int          m_state;   // 0 hunt, 1 sync, 2 locked
    logic [31:0] m_exp;
    int          m_match;
    int          m_bad;
    longint      m_wc, m_ew, m_be;
    bit          m_sticky;
    logic [31:0] cur;

    // Slide a 32-bit window along the bit stream one bit at a time
    function automatic logic [31:0] ref_next(input logic [31:0] w);
        logic [31:0] win;
        win = w;
        for (int i = 0; i < 32; i++) win = {win[1] ^ win[4], win[31:1]};
        return win;
    endfunction

    function automatic logic [63:0] sat(input longint x, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (x > mx) ? mx : x;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_exp = '0; m_match = 0; m_bad = 0;
        m_wc = 0; m_ew = 0; m_be = 0; m_sticky = 1'b0;
    endtask

    task automatic model_step(input bit v, input logic [31:0] d, input bit c);
        int nerr;
        if (v) begin
            case (m_state)
                0: if (d != 0) begin m_exp = ref_next(d); m_match = 0; m_state = 1; end
                1: begin
                    if (d == m_exp) begin
                        m_match++;
                        m_exp = ref_next(d);
                        if (m_match == 16) begin m_state = 2; m_bad = 0; end
                    end else if (d != 0) begin
                        m_exp = ref_next(d); m_match = 0;
                    end else begin
                        m_state = 0;
                    end
                end
                default: begin
                    nerr  = $countones(d ^ m_exp);
                    m_exp = ref_next(m_exp);
                    m_wc++;
                    if (nerr == 0) m_bad = 0;
                    else begin
                        m_ew++; m_be += nerr; m_sticky = 1'b1; m_bad++;
                        if (m_bad == 8) m_state = 0;
                    end
                end
            endcase
        end
        if (c) begin m_wc = 0; m_ew = 0; m_be = 0; m_sticky = 1'b0; end
    endtask

    task automatic send(input bit v, input logic [31:0] d, input bit c);
        @(negedge clk);
        bus_a.rx_valid = v; bus_a.rx_data = d; bus_a.clr = c;
        bus_b.rx_valid = v; bus_b.rx_data = d; bus_b.clr = c;
        @(posedge clk);
        model_step(v, d, c);
        #1;
        bus_a.rx_valid = 1'b0; bus_a.clr = 1'b0;
        bus_b.rx_valid = 1'b0; bus_b.clr = 1'b0;
    endtask

    task automatic send_clean(input logic [31:0] x, input bit c);
        send(1'b1, cur ^ x, c);
        cur = ref_next(cur);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_status_a", bus_a.status, 4'b0001);
        chk("rst_status_b", bus_b.status, 4'b0001);
        chk("rst_locked_a", bus_a.locked, 0);
        chk("rst_wc_a", bus_a.words_checked, 0);
        chk("rst_ew_a", bus_a.err_words, 0);
        chk("rst_be_a", bus_a.bit_errs, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        started = 1'b1;
    endtask

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (started && !rst) begin
            chk("locked_a", bus_a.locked, m_state == 2);
            chk("locked_b", bus_b.locked, m_state == 2);
            chk("sticky_a", bus_a.err_sticky, m_sticky);
            chk("sticky_b", bus_b.err_sticky, m_sticky);
            chk("status_a", bus_a.status, {m_sticky, m_state == 2, m_state == 1, m_state == 0});
            chk("status_b", bus_b.status, {m_sticky, m_state == 2, m_state == 1, m_state == 0});
            chk("words_checked_a", bus_a.words_checked, sat(m_wc, 32));
            chk("words_checked_b", bus_b.words_checked, sat(m_wc, 4));
            chk("err_words_a", bus_a.err_words, sat(m_ew, 32));
            chk("err_words_b", bus_b.err_words, sat(m_ew, 4));
            chk("bit_errs_a", bus_a.bit_errs, sat(m_be, 32));
            chk("bit_errs_b", bus_b.bit_errs, sat(m_be, 4));
        end
    end

    initial begin
        n_checks = 0; n_err = 0; started = 1'b0;
        rst = 1'b0;
        bus_a.rx_valid = 1'b0; bus_a.rx_data = '0; bus_a.clr = 1'b0;
        bus_b.rx_valid = 1'b0; bus_b.rx_data = '0; bus_b.clr = 1'b0;
        model_reset();

        // Hand-derived successor words pin the reference recurrence
        chk("ref_next_2", ref_next(32'h0000_0002), 32'h9000_0001);
        chk("ref_next_10", ref_next(32'h0000_0010), 32'h1000_0009);
        chk("ref_next_1", ref_next(32'h0000_0001), 32'h0000_0000);

        do_reset();

        // All-zero stream keeps the block hunting
        repeat (5) send(1'b1, 32'h0, 1'b0);
        chk("zero_hunt", bus_a.status, 4'b0001);

        // Clean lock: seed plus 16 matches
        cur = 32'hACE1_2345;
        send_clean(32'h0, 1'b0);
        chk("first_word_sync", bus_a.status, 4'b0010);
        repeat (15) send_clean(32'h0, 1'b0);
        chk("not_locked_16", bus_a.locked, 0);
        send_clean(32'h0, 1'b0);
        chk("locked_17", bus_a.locked, 1);
        repeat (100) send_clean(32'h0, 1'b0);
        chk("clean_wc_100", bus_a.words_checked, 100);
        chk("clean_ew_0", bus_a.err_words, 0);
        chk("clean_be_0", bus_a.bit_errs, 0);

        // Single-bit error on bit 5
        send_clean(32'h0000_0020, 1'b0);
        chk("single_ew", bus_a.err_words, 1);
        chk("single_be", bus_a.bit_errs, 1);
        chk("single_status", bus_a.status, 4'b1100);
        repeat (10) send_clean(32'h0, 1'b0);
        chk("single_hold_lock", bus_a.locked, 1);

        // Loss of lock after 8 inverted words, then relock
        send_clean(32'h0, 1'b1);
        repeat (7) send_clean(32'hFFFF_FFFF, 1'b0);
        chk("still_locked_7", bus_a.locked, 1);
        send_clean(32'hFFFF_FFFF, 1'b0);
        chk("unlock_ew", bus_a.err_words, 8);
        chk("unlock_be", bus_a.bit_errs, 256);
        chk("unlock_status", bus_a.status, 4'b1001);
        repeat (16) send_clean(32'h0, 1'b0);
        chk("relock_not_16", bus_a.locked, 0);
        send_clean(32'h0, 1'b0);
        chk("relock_17", bus_a.locked, 1);

        // Valid gaps: lock and counting follow valid words only
        do_reset();
        for (int i = 0; i < 17; i++) begin
            repeat ($urandom_range(0, 3)) send(1'b0, $urandom, 1'b0);
            send_clean(32'h0, 1'b0);
            if (i == 15) chk("gap_not_locked_16", bus_a.locked, 0);
        end
        chk("gap_locked_17", bus_a.locked, 1);
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 3)) send(1'b0, $urandom, 1'b0);
            send_clean(32'h0, 1'b0);
        end
        chk("gap_wc_30", bus_a.words_checked, 30);

        // clr coincident with an errored word wins
        send_clean(32'h0000_0001, 1'b1);
        chk("clr_ew", bus_a.err_words, 0);
        chk("clr_be", bus_a.bit_errs, 0);
        chk("clr_sticky", bus_a.err_sticky, 0);
        chk("clr_wc", bus_a.words_checked, 0);

        // Saturation on the 4-bit instance, errors interleaved with clean words
        send_clean(32'h0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            send_clean(32'h0000_0100, 1'b0);
            send_clean(32'h0, 1'b0);
        end
        chk("sat_ew_b", bus_b.err_words, 15);
        chk("sat_be1_b", bus_b.bit_errs, 15);
        chk("sat_wc_b", bus_b.words_checked, 15);
        chk("sat_ew_a", bus_a.err_words, 20);
        send_clean(32'h0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            send_clean(32'h0000_0007, 1'b0);
            send_clean(32'h0, 1'b0);
        end
        chk("sat_be3_b", bus_b.bit_errs, 15);
        chk("sat_be3_a", bus_a.bit_errs, 60);
        chk("sat_lock_held", bus_a.locked, 1);

        // Asynchronous reset while locked clears everything at once
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        chk("midrst_status_a", bus_a.status, 4'b0001);
        chk("midrst_status_b", bus_b.status, 4'b0001);
        chk("midrst_wc_a", bus_a.words_checked, 0);
        chk("midrst_be_b", bus_b.bit_errs, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/sfp_prbs_checker.md
# sfp_prbs_checker

Receive-side checker for the SFP0 link test path. It consumes the 32-bit parallel receive words recovered by the GTH transceiver driver, self-synchronises to the PRBS-31 pattern transmitted on SFP0, and counts word and bit errors. Its 4-bit status vector drives the `gth_status` input of the system wrapper, where software reads it. This allows link validation without the classical NIC.

## Interface
Parameters:
- `LOCK_WORDS`, 16: consecutive matching words after seeding that are required to declare lock.
- `UNLOCK_WORDS`, 8: consecutive errored words while locked that drop lock.
- `CNT_WIDTH`, 32: width of the saturating counters.

Ports:
- `clk`  in  1: receive user clock. All logic is in this single clock domain.
- `rst`  in  1: reset, asynchronous and active-high.
- `rx_data`  in  32: receive word. Bit 0 is the earliest received bit.
- `rx_valid`  in  1: `rx_data` is valid this cycle. There is no backpressure.
- `clr`  in  1: synchronous pulse that clears the counters and `err_sticky`.
- `locked`  out  1: the checker is in state LOCKED.
- `err_sticky`  out  1: at least one errored word has been seen since reset or `clr`.
- `words_checked`  out  CNT_WIDTH: number of valid words compared while LOCKED.
- `err_words`  out  CNT_WIDTH: number of mismatching words while LOCKED.
- `bit_errs`  out  CNT_WIDTH: total mismatching bits while LOCKED.
- `status`  out  4: the vector {err_sticky, locked, state==SYNC, state==HUNT}.

## Operation
- Bit stream recurrence: b[n] = b[n-31] XOR b[n-28]. This is x^31+x^28+1, non-inverted.
- next(w) gives the 32-bit word that follows word w, computed bit by bit from the recurrence:
  - For j < 28, the bits b[n-31] and b[n-28] come from w.
  - For j ≥ 28, b[n-28] comes from bits of the new word that have already been computed.
  - The function is combinational.
- Cycles with `rx_valid`=0 are ignored completely: no state change, no counting.
- State HUNT (reset state):
  - On a valid word that is non-zero: `expected` ← next(rx_data), `match_cnt` ← 0, go to SYNC.
  - On a valid word of all zeros: stay in HUNT.
- State SYNC (self-synchronising; the prediction is taken from the received data):
  - Valid word equal to `expected`:
    - `match_cnt`++, `expected` ← next(rx_data).
    - If `match_cnt` reaches LOCK_WORDS: go to LOCKED and set `bad_cnt` ← 0.
  - Valid word not equal to `expected`:
    - If the word is non-zero: reseed with `expected` ← next(rx_data) and `match_cnt` ← 0.
    - If the word is zero: go to HUNT.
  - No counters change in SYNC.
- State LOCKED (free-running; the prediction is taken from `expected`, so errors do not propagate):
  - Every valid word: `expected` ← next(expected) and `words_checked`++.
  - Word matches `expected`: `bad_cnt` ← 0.
  - Word mismatches:
    - `err_words`++.
    - `bit_errs` += popcount(rx_data XOR expected), a value from 0 to 32.
    - `err_sticky` ← 1.
    - `bad_cnt`++.
    - When `bad_cnt` reaches UNLOCK_WORDS: go to HUNT.
- All counters saturate at 2^CNT_WIDTH−1 and never wrap. For `bit_errs`, an addition that would overflow clamps to all-ones.
- `clr` takes precedence: on the edge where `clr`=1, all three counters and `err_sticky` become 0. Any increment from that same cycle is discarded. The state machine still processes the word normally.
- Reset mid-operation: the block returns immediately to HUNT and clears all registers. No partial counts are kept.

## Timing
- Reset values:
  - `locked`=0, `err_sticky`=0.
  - All counters 0.
  - `status`=4'b0001.
  - Internal registers `expected`, `match_cnt` and `bad_cnt` are 0.
- All outputs are registered. Counters, `err_sticky`, `locked` and `status` reflect a valid word on the cycle after it is presented, i.e. 1-cycle latency.
- Lock latency in a clean stream:
  - The word that enters LOCKED is the (LOCK_WORDS+1)-th valid word: 1 seed word plus LOCK_WORDS matches.
  - `locked` rises 1 cycle after that word.
  - Counting starts with the next valid word.
- Unlock: `locked` falls 1 cycle after the UNLOCK_WORDS-th consecutive errored word. That word is itself counted.
- The block accepts back-to-back valid words at full rate, one per clock.

## Test plan
- **Reset and idle:**
  - Assert `rst` with no valid words: all counters 0 and `status`=4'b0001.
  - Apply an all-zero stream with `rx_valid`=1: the block stays in HUNT.
- **Clean lock:**
  - Apply a continuous PRBS-31 stream, defaults, starting from any non-zero word: `status`=4'b0010 after the 1st word, `locked`=1 one cycle after the 17th word.
  - After 100 further words: `words_checked`=100, `err_words`=0, `bit_errs`=0.
- **Single-bit error:**
  - While locked, flip bit 5 of one word: `err_words`=1, `bit_errs`=1, `err_sticky`=1, `status`=4'b1100.
  - The following words match, so `bad_cnt` clears and lock holds.
- **Loss of lock:**
  - XOR 8 consecutive locked words with 0xFFFFFFFF: `err_words`=8, `bit_errs`=256, `locked`=0 one cycle after the 8th word, `status`=4'b1001.
  - The stream then relocks after 17 more clean words.
- **Valid gaps and clr:**
  - Insert random `rx_valid`=0 cycles into a clean stream: lock still occurs on the 17th valid word, and `words_checked` counts only valid words.
  - Pulse `clr` on the same cycle as an errored word: counters and `err_sticky` read 0 afterwards.
- **Saturation (CNT_WIDTH=4):**
  - Feed 20 errored words, each with 1 bit flipped, so `bad_cnt` stays below 8: `err_words` holds at 15.
  - Repeat with 3 bits flipped per word: `bit_errs` holds at 15 and does not wrap.
